// File: rtl/pong_frame_sequencer_pkg.sv
// pong_frame_sequencer_pkg
// Shared geometry and sequencing constants for the pong game-state logic.
// The renderer draws with these same numbers, so a hit test here lands on
// exactly the pixels the player sees.
//   - Screen, pad and ball geometry, plus speeds and the winning score
//   - Derived hit lines (XL/XR), pad clamp range and ball limits
//   - Encoding of the per-frame update sequence states
//   - abs10: magnitude of a 10-bit signed distance
package pong_frame_sequencer_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int PAD_HEIGHT    = 64;
  localparam int PAD_WIDTH     = 8;
  localparam int PAD_DISTANCE  = 16;
  localparam int BALL_SIZE     = 8;
  localparam int PAD_SPEED     = 4;
  localparam int BALL_SPEED    = 2;
  localparam int WIN_SCORE     = 9;
  localparam int SERVE_FRAMES  = 60;

  localparam int HALF_BALL  = BALL_SIZE / 2;
  // Ball centre x at which the ball touches a pad face.
  localparam int XL         = PAD_DISTANCE + PAD_WIDTH + HALF_BALL;
  localparam int XR         = SCREEN_WIDTH - XL;
  localparam int PAD_MIN    = PAD_HEIGHT / 2;
  localparam int PAD_MAX    = SCREEN_HEIGHT - PAD_HEIGHT / 2;
  localparam int BALL_X_MIN = HALF_BALL;
  localparam int BALL_X_MAX = SCREEN_WIDTH - HALF_BALL;
  localparam int BALL_Y_MIN = HALF_BALL;
  localparam int BALL_Y_MAX = SCREEN_HEIGHT - HALF_BALL;
  // Pad and ball overlap vertically while the centres are closer than this.
  localparam int HIT_RANGE  = PAD_HEIGHT / 2 + HALF_BALL;
  localparam int CENTRE_X   = SCREEN_WIDTH / 2;
  localparam int CENTRE_Y   = SCREEN_HEIGHT / 2;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PADS     = 3'd1;
  localparam logic [2:0] ST_BALL     = 3'd2;
  localparam logic [2:0] ST_BOUNCE_Y = 3'd3;
  localparam logic [2:0] ST_BOUNCE_X = 3'd4;
  localparam logic [2:0] ST_SCORE    = 3'd5;
  localparam logic [2:0] ST_COMMIT   = 3'd6;

  function automatic logic signed [9:0] abs10(input logic signed [9:0] v);
    return (v < 0) ? -v : v;
  endfunction

endpackage

// File: rtl/pong_pad_mover.sv
// pong_pad_mover
// Computes the next centre position of one pad from its current position
// and the player's two buttons. Purely combinational; the sequencer latches
// the result during its pad-update step.
// Ports:
//   pos      in  9  current pad centre y
//   up       in  1  move-up button
//   dn       in  1  move-down button
//   next_pos out 9  new pad centre y, clamped to [PAD_MIN, PAD_MAX]
module pong_pad_mover
  import pong_frame_sequencer_pkg::*;
(
  input  logic [8:0] pos,
  input  logic       up,
  input  logic       dn,
  output logic [8:0] next_pos
);

  localparam logic signed [9:0] SPEED = 10'(PAD_SPEED);
  localparam logic signed [9:0] LO    = 10'(PAD_MIN);
  localparam logic signed [9:0] HI    = 10'(PAD_MAX);

  logic signed [9:0] stepped;

  // One extra bit and signed compare so a step below the top edge clamps
  // instead of wrapping to a large value.
  always_comb begin
    stepped = $signed({1'b0, pos});
    if (up && !dn) begin
      stepped = $signed({1'b0, pos}) - SPEED;
    end else if (dn && !up) begin
      stepped = $signed({1'b0, pos}) + SPEED;
    end
    if (stepped < LO) begin
      next_pos = LO[8:0];
    end else if (stepped > HI) begin
      next_pos = HI[8:0];
    end else begin
      next_pos = stepped[8:0];
    end
  end

endmodule

// File: rtl/pong_frame_sequencer.sv
// pong_frame_sequencer
// Per-frame pong game-state controller. On each falling edge of VGA_VS it
// runs PADS -> BALL -> BOUNCE_Y -> BOUNCE_X -> SCORE -> COMMIT on working
// copies of the game state, then publishes everything in one cycle so the
// renderer never sees a half-updated frame.
// Optional feature macro: PONG_SERVE_DELAY_EN (hold the ball at centre for
// SERVE_FRAMES frames after every serve).
// Ports:
//   clk_vga   in   1  pixel clock
//   rst       in   1  asynchronous active-high reset
//   VGA_VS    in   1  active-low vertical sync, same clock domain
//   btn_l_up, btn_l_dn, btn_r_up, btn_r_dn  in 1  player buttons
//   start     in   1  one-cycle pulse: clear scores and serve
//   pad_left  out  9  left pad centre y
//   pad_right out  9  right pad centre y
//   ball_x    out 10  ball centre x
//   ball_y    out  9  ball centre y
//   score_l   out  4  left player score
//   score_r   out  4  right player score
//   game_over out  1  a player has reached WIN_SCORE
//   busy      out  1  update sequence in progress
module pong_frame_sequencer
  import pong_frame_sequencer_pkg::*;
(
  input  logic       clk_vga,
  input  logic       rst,
  input  logic       VGA_VS,
  input  logic       btn_l_up,
  input  logic       btn_l_dn,
  input  logic       btn_r_up,
  input  logic       btn_r_dn,
  input  logic       start,
  output logic [8:0] pad_left,
  output logic [8:0] pad_right,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic       busy
);

  localparam logic signed [10:0] X_CENTRE = 11'(CENTRE_X);
  localparam logic signed [9:0]  Y_CENTRE = 10'(CENTRE_Y);
  localparam logic signed [10:0] X_STEP   = 11'(BALL_SPEED);
  localparam logic signed [9:0]  Y_STEP   = 10'(BALL_SPEED);
  localparam logic signed [10:0] X_HIT_L  = 11'(XL);
  localparam logic signed [10:0] X_HIT_R  = 11'(XR);
  localparam logic signed [10:0] X_MIN    = 11'(BALL_X_MIN);
  localparam logic signed [10:0] X_MAX    = 11'(BALL_X_MAX);
  localparam logic signed [9:0]  Y_MIN    = 10'(BALL_Y_MIN);
  localparam logic signed [9:0]  Y_MAX    = 10'(BALL_Y_MAX);
  localparam logic signed [9:0]  HIT      = 10'(HIT_RANGE);
  localparam logic [8:0]         PAD_RST  = 9'(CENTRE_Y);
  localparam logic [3:0]         WIN      = 4'(WIN_SCORE);

  logic [2:0]         state;
  logic               vs_q;
  logic               frame_tick;
  logic               start_pend;
  logic [8:0]         w_pad_l;
  logic [8:0]         w_pad_r;
  logic [8:0]         pad_l_next;
  logic [8:0]         pad_r_next;
  logic signed [10:0] w_x;
  logic signed [9:0]  w_y;
  logic               w_dx;
  logic               w_dy;
  logic [3:0]         w_score_l;
  logic [3:0]         w_score_r;
  logic               w_game_over;
  logic               miss_l;
  logic               miss_r;
  logic signed [10:0] prev_x;
  logic signed [10:0] step_x;
  logic signed [9:0]  step_y;
  logic signed [9:0]  dist_l;
  logic signed [9:0]  dist_r;
  logic               ball_hold;

  pong_pad_mover u_pad_l (
    .pos      (w_pad_l),
    .up       (btn_l_up),
    .dn       (btn_l_dn),
    .next_pos (pad_l_next)
  );

  pong_pad_mover u_pad_r (
    .pos      (w_pad_r),
    .up       (btn_r_up),
    .dn       (btn_r_dn),
    .next_pos (pad_r_next)
  );

  assign frame_tick = vs_q & ~VGA_VS;
  assign busy       = (state != ST_IDLE);

  // The published ball_x is last frame's position, since outputs only move
  // at COMMIT; it serves as the "previous x" for the hit-line crossing test.
  assign prev_x = $signed({1'b0, ball_x});
  assign step_x = w_dx ? (w_x + X_STEP) : (w_x - X_STEP);
  assign step_y = w_dy ? (w_y + Y_STEP) : (w_y - Y_STEP);
  assign dist_l = abs10(w_y - $signed({1'b0, w_pad_l}));
  assign dist_r = abs10(w_y - $signed({1'b0, w_pad_r}));

`ifdef PONG_SERVE_DELAY_EN
  logic [7:0] serve_cnt;
  assign ball_hold = (serve_cnt != 8'd0);
`else
  assign ball_hold = 1'b0;
`endif

  // Sequencer: each state performs one stage of the frame update on the
  // working copies; COMMIT publishes them (or the start-of-game state).
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      vs_q        <= 1'b1;
      start_pend  <= 1'b0;
      w_pad_l     <= PAD_RST;
      w_pad_r     <= PAD_RST;
      w_x         <= X_CENTRE;
      w_y         <= Y_CENTRE;
      w_dx        <= 1'b1;
      w_dy        <= 1'b1;
      w_score_l   <= 4'd0;
      w_score_r   <= 4'd0;
      w_game_over <= 1'b0;
      miss_l      <= 1'b0;
      miss_r      <= 1'b0;
      pad_left    <= PAD_RST;
      pad_right   <= PAD_RST;
      ball_x      <= X_CENTRE[9:0];
      ball_y      <= Y_CENTRE[8:0];
      score_l     <= 4'd0;
      score_r     <= 4'd0;
      game_over   <= 1'b0;
`ifdef PONG_SERVE_DELAY_EN
      serve_cnt   <= 8'd0;
`endif
    end else begin
      vs_q <= VGA_VS;
      if (start) begin
        start_pend <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (frame_tick) begin
            state <= ST_PADS;
          end
        end
        ST_PADS: begin
          w_pad_l <= pad_l_next;
          w_pad_r <= pad_r_next;
          miss_l  <= 1'b0;
          miss_r  <= 1'b0;
          state   <= ST_BALL;
        end
        ST_BALL: begin
          if (!w_game_over && !ball_hold) begin
            w_x <= step_x;
            w_y <= step_y;
          end
`ifdef PONG_SERVE_DELAY_EN
          if (ball_hold) begin
            serve_cnt <= serve_cnt - 8'd1;
          end
`endif
          state <= ST_BOUNCE_Y;
        end
        ST_BOUNCE_Y: begin
          if (w_y <= Y_MIN) begin
            w_y  <= Y_MIN;
            w_dy <= 1'b1;
          end else if (w_y >= Y_MAX) begin
            w_y  <= Y_MAX;
            w_dy <= 1'b0;
          end
          state <= ST_BOUNCE_X;
        end
        ST_BOUNCE_X: begin
          // A pad bounce requires crossing the hit line this frame, so a
          // ball already behind the pad keeps travelling to the miss line.
          if (!w_dx) begin
            if (prev_x > X_HIT_L && w_x <= X_HIT_L && dist_l < HIT) begin
              w_x  <= X_HIT_L;
              w_dx <= 1'b1;
            end else if (w_x <= X_MIN) begin
              miss_l <= 1'b1;
            end
          end else begin
            if (prev_x < X_HIT_R && w_x >= X_HIT_R && dist_r < HIT) begin
              w_x  <= X_HIT_R;
              w_dx <= 1'b0;
            end else if (w_x >= X_MAX) begin
              miss_r <= 1'b1;
            end
          end
          state <= ST_BOUNCE_X + 3'd1;
        end
        ST_SCORE: begin
          // The serve heads toward whoever conceded; dy is left as it was.
          if (miss_l) begin
            if (w_score_r < WIN) begin
              w_score_r <= w_score_r + 4'd1;
            end
            if (w_score_r >= WIN - 4'd1) begin
              w_game_over <= 1'b1;
            end
            w_x  <= X_CENTRE;
            w_y  <= Y_CENTRE;
            w_dx <= 1'b0;
`ifdef PONG_SERVE_DELAY_EN
            serve_cnt <= 8'(SERVE_FRAMES);
`endif
          end else if (miss_r) begin
            if (w_score_l < WIN) begin
              w_score_l <= w_score_l + 4'd1;
            end
            if (w_score_l >= WIN - 4'd1) begin
              w_game_over <= 1'b1;
            end
            w_x  <= X_CENTRE;
            w_y  <= Y_CENTRE;
            w_dx <= 1'b1;
`ifdef PONG_SERVE_DELAY_EN
            serve_cnt <= 8'(SERVE_FRAMES);
`endif
          end
          state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          pad_left  <= w_pad_l;
          pad_right <= w_pad_r;
          // A pending start overrides whatever this frame's scoring did.
          if (start_pend) begin
            w_score_l   <= 4'd0;
            w_score_r   <= 4'd0;
            w_game_over <= 1'b0;
            w_x         <= X_CENTRE;
            w_y         <= Y_CENTRE;
            w_dx        <= 1'b1;
            score_l     <= 4'd0;
            score_r     <= 4'd0;
            game_over   <= 1'b0;
            ball_x      <= X_CENTRE[9:0];
            ball_y      <= Y_CENTRE[8:0];
`ifdef PONG_SERVE_DELAY_EN
            serve_cnt   <= 8'(SERVE_FRAMES);
`endif
          end else begin
            score_l   <= w_score_l;
            score_r   <= w_score_r;
            game_over <= w_game_over;
            ball_x    <= w_x[9:0];
            ball_y    <= w_y[8:0];
          end
          // A start arriving in this very cycle waits for the next commit.
          start_pend <= start;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_frame_sequencer.sv
// tb_pong_frame_sequencer
// Directed bench for pong_frame_sequencer. Ball trajectories are followed
// from reset frame by frame; expected positions follow from +/-2 per frame
// per axis with the wall, pad and miss lines at 4/476, 28/612 and 4/636.
module tb_pong_frame_sequencer;

  logic       clk_vga;
  logic       rst;
  logic       VGA_VS;
  logic       btn_l_up;
  logic       btn_l_dn;
  logic       btn_r_up;
  logic       btn_r_dn;
  logic       start;
  logic [8:0] pad_left;
  logic [8:0] pad_right;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;
  logic       busy;

  int checks;
  int errors;
  int busy_cycles;

  // Button vectors packed as {l_up, l_dn, r_up, r_dn}.
  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] L_UP = 4'b1000;
  localparam logic [3:0] L_DN = 4'b0100;
  localparam logic [3:0] R_DN = 4'b0001;
  localparam logic [3:0] ALL  = 4'b1111;

  pong_frame_sequencer dut (
    .clk_vga   (clk_vga),
    .rst       (rst),
    .VGA_VS    (VGA_VS),
    .btn_l_up  (btn_l_up),
    .btn_l_dn  (btn_l_dn),
    .btn_r_up  (btn_r_up),
    .btn_r_dn  (btn_r_dn),
    .start     (start),
    .pad_left  (pad_left),
    .pad_right (pad_right),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .score_l   (score_l),
    .score_r   (score_r),
    .game_over (game_over),
    .busy      (busy)
  );

  initial clk_vga = 1'b0;
  always #5 clk_vga = ~clk_vga;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One frame: a single-cycle low pulse on VGA_VS, then wait (bounded) for
  // the sequence to finish, counting the busy cycles seen.
  task automatic runFrame(input logic [3:0] btns);
    {btn_l_up, btn_l_dn, btn_r_up, btn_r_dn} = btns;
    @(negedge clk_vga);
    VGA_VS = 1'b0;
    @(negedge clk_vga);
    VGA_VS = 1'b1;
    busy_cycles = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      busy_cycles++;
      @(negedge clk_vga);
    end
    if (busy) checkOutput("frame_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic applyStimulus(input int frames, input logic [3:0] btns);
    for (int f = 0; f < frames; f++) begin
      runFrame(btns);
    end
  endtask

  task automatic pulseReset();
    @(negedge clk_vga);
    rst = 1'b1;
    @(negedge clk_vga);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    busy_cycles = 0;
    rst = 1'b1;
    VGA_VS = 1'b1;
    {btn_l_up, btn_l_dn, btn_r_up, btn_r_dn} = NONE;
    start = 1'b0;
    repeat (2) @(negedge clk_vga);

    checkOutput("rst_pad_left", pad_left, 240);
    checkOutput("rst_pad_right", pad_right, 240);
    checkOutput("rst_ball_x", ball_x, 320);
    checkOutput("rst_ball_y", ball_y, 240);
    checkOutput("rst_scores", {score_l, score_r}, 0);
    checkOutput("rst_game_over", game_over, 0);
    checkOutput("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk_vga);

    // Run 1: free ball, pad moves, right-pad bounce, top wall, left-pad bounce.
    runFrame(NONE);
    checkOutput("f1_busy_cycles", busy_cycles, 6);
    checkOutput("f1_ball", {ball_x, 6'd0, ball_y}, {10'd322, 6'd0, 9'd242});
    runFrame(NONE);
    checkOutput("f2_busy_cycles", busy_cycles, 6);
    checkOutput("f2_ball", {ball_x, 6'd0, ball_y}, {10'd324, 6'd0, 9'd244});
    runFrame(NONE);
    checkOutput("f3_busy_cycles", busy_cycles, 6);
    checkOutput("f3_ball", {ball_x, 6'd0, ball_y}, {10'd326, 6'd0, 9'd246});
    checkOutput("f3_pads", {pad_left, pad_right}, {9'd240, 9'd240});

    runFrame(L_UP);
    checkOutput("f4_pad_left", pad_left, 236);
    applyStimulus(51, L_UP);
    checkOutput("f55_pad_left_min", pad_left, 32);
    applyStimulus(8, L_UP);
    checkOutput("f63_pad_left_clamped", pad_left, 32);
    runFrame(ALL);
    checkOutput("f64_both_left", pad_left, 32);
    checkOutput("f64_both_right", pad_right, 240);
    applyStimulus(45, R_DN);
    checkOutput("f109_pad_right", pad_right, 420);

    applyStimulus(9, NONE);
    checkOutput("f118_bottom_wall", {ball_x, 6'd0, ball_y}, {10'd556, 6'd0, 9'd476});
    runFrame(NONE);
    checkOutput("f119_moving_up", ball_y, 474);
    applyStimulus(27, NONE);
    checkOutput("f146_right_pad_hit", {ball_x, 6'd0, ball_y}, {10'd612, 6'd0, 9'd420});
    runFrame(NONE);
    checkOutput("f147_moving_left", ball_x, 610);
    applyStimulus(207, NONE);
    checkOutput("f354_top_wall", {ball_x, 6'd0, ball_y}, {10'd196, 6'd0, 9'd4});
    runFrame(NONE);
    checkOutput("f355_moving_down", ball_y, 6);
    applyStimulus(35, L_DN);
    checkOutput("f390_pad_left", pad_left, 172);
    applyStimulus(48, NONE);
    checkOutput("f438_left_pad_hit", {ball_x, 6'd0, ball_y}, {10'd28, 6'd0, 9'd172});
    runFrame(NONE);
    checkOutput("f439_moving_right", {ball_x, 6'd0, ball_y}, {10'd30, 6'd0, 9'd174});
    checkOutput("f439_no_score", {score_l, score_r}, 0);

    // Run 2: same path, but the left pad stays at 240 and the ball is missed.
    pulseReset();
    applyStimulus(45, R_DN);
    checkOutput("r2_pad_right", pad_right, 420);
    applyStimulus(404, NONE);
    checkOutput("r2_f449_past_pad", ball_x, 6);
    checkOutput("r2_f449_score_r", score_r, 0);
    runFrame(NONE);
    checkOutput("r2_f450_score_r", score_r, 1);
    checkOutput("r2_f450_score_l", score_l, 0);
    checkOutput("r2_f450_serve", {ball_x, 6'd0, ball_y}, {10'd320, 6'd0, 9'd240});
    runFrame(NONE);
    checkOutput("r2_f451_serve_left", {ball_x, 6'd0, ball_y}, {10'd318, 6'd0, 9'd242});

    // Reset while the sequence sits in BOUNCE_X.
    {btn_l_up, btn_l_dn, btn_r_up, btn_r_dn} = L_UP;
    @(negedge clk_vga);
    VGA_VS = 1'b0;
    @(negedge clk_vga);
    VGA_VS = 1'b1;
    repeat (3) @(negedge clk_vga);
    checkOutput("midseq_busy", busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("midseq_rst_busy", busy, 0);
    checkOutput("midseq_rst_ball", {ball_x, 6'd0, ball_y}, {10'd320, 6'd0, 9'd240});
    checkOutput("midseq_rst_score_r", score_r, 0);
    checkOutput("midseq_rst_pad_left", pad_left, 240);
    @(negedge clk_vga);
    rst = 1'b0;
    {btn_l_up, btn_l_dn, btn_r_up, btn_r_dn} = NONE;

    // A second VGA_VS falling edge during busy must not start another pass.
    @(negedge clk_vga);
    VGA_VS = 1'b0;
    @(negedge clk_vga);
    VGA_VS = 1'b1;
    @(negedge clk_vga);
    VGA_VS = 1'b0;
    @(negedge clk_vga);
    VGA_VS = 1'b1;
    busy_cycles = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      busy_cycles++;
      @(negedge clk_vga);
    end
    checkOutput("busy_tick_remaining", busy_cycles, 4);
    repeat (4) @(negedge clk_vga);
    checkOutput("busy_tick_ignored", busy, 0);
    checkOutput("busy_tick_ball", {ball_x, 6'd0, ball_y}, {10'd322, 6'd0, 9'd242});

    // Run 3: a right miss every 158 frames until score_l reaches 9.
    pulseReset();
    applyStimulus(1421, NONE);
    checkOutput("r3_score_l_8", score_l, 8);
    checkOutput("r3_not_over", game_over, 0);
    runFrame(NONE);
    checkOutput("r3_score_l_9", score_l, 9);
    checkOutput("r3_game_over", game_over, 1);
    checkOutput("r3_serve", {ball_x, 6'd0, ball_y}, {10'd320, 6'd0, 9'd240});
    runFrame(NONE);
    checkOutput("r3_frozen", {ball_x, 6'd0, ball_y}, {10'd320, 6'd0, 9'd240});
    checkOutput("r3_score_held", score_l, 9);

    @(negedge clk_vga);
    start = 1'b1;
    @(negedge clk_vga);
    start = 1'b0;
    checkOutput("start_waits_commit", score_l, 9);
    runFrame(NONE);
    checkOutput("start_scores", {score_l, score_r}, 0);
    checkOutput("start_game_over", game_over, 0);
    checkOutput("start_ball", {ball_x, 6'd0, ball_y}, {10'd320, 6'd0, 9'd240});
    runFrame(NONE);
    checkOutput("start_serve_right", {ball_x, 6'd0, ball_y}, {10'd322, 6'd0, 9'd238});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
